// File: rtl/div_nr_pkg.sv
// rtl/div_nr_pkg.sv - shared state type, counter sizing and constants for div_nr_seq
package div_nr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Quotient reported on divide-by-zero; sliced to the operand width at use.
  localparam logic [63:0] DZ_QUOTIENT = '1;

  // Iteration counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// rtl/div_nr_step.sv - one combinational non-restoring division iteration
module div_nr_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] a_sh;

  // Shift {A,Q} left, then subtract M when A was non-negative or add it back when negative.
  always_comb begin
    a_sh = {a[WIDTH-1:0], q[WIDTH-1]};
    if (a[WIDTH]) begin
      a_next = a_sh + {1'b0, m};
    end else begin
      a_next = a_sh - {1'b0, m};
    end
    q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};
  end

endmodule

// File: rtl/div_nr_seq.sv
// rtl/div_nr_seq.sv - sequential non-restoring divider; DIV_NR_SIGNED_EN enables signed operation
module div_nr_seq
  import div_nr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic             load, iter, fix, dz;
  logic [WIDTH:0]   a_q, a_step;
  logic [WIDTH-1:0] q_q, q_step, m_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dd_mag, dv_mag, r_mag, q_res, r_res;

  // Final correction: a negative partial remainder gets M added back.
  assign r_mag = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];

`ifdef DIV_NR_SIGNED_EN
  logic dd_neg, dv_neg, q_neg_q, r_neg_q;

  assign dd_neg = signed_op & dividend[WIDTH-1];
  assign dv_neg = signed_op & divisor[WIDTH-1];
  assign dd_mag = dd_neg ? -dividend : dividend;
  assign dv_mag = dv_neg ? -divisor : divisor;
  assign q_res  = q_neg_q ? -q_q : q_q;
  assign r_res  = r_neg_q ? -r_mag : r_mag;

  // Result signs captured with the operands: quotient negative on differing signs, remainder follows dividend.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (load) begin
      q_neg_q <= dd_neg ^ dv_neg;
      r_neg_q <= dd_neg;
    end
  end
`else
  logic signed_op_unused;

  assign signed_op_unused = signed_op;
  assign dd_mag = dividend;
  assign dv_mag = divisor;
  assign q_res  = q_q;
  assign r_res  = r_mag;
`endif

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_q),
    .q      (q_q),
    .m      (m_q),
    .a_next (a_step),
    .q_next (q_step)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dz      = 1'b0;
    iter    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            dz = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        iter = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        fix     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working registers: load magnitudes, then advance one quotient bit per ITER cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= '0;
      q_q   <= dd_mag;
      m_q   <= dv_mag;
      cnt_q <= '0;
    end else if (iter) begin
      a_q   <= a_step;
      q_q   <= q_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Visible outputs: results only change together with a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= dz | fix;
      if (load) begin
        busy <= 1'b1;
      end else if (fix) begin
        busy <= 1'b0;
      end
      if (dz) begin
        quotient    <= DZ_QUOTIENT[WIDTH-1:0];
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else if (fix) begin
        quotient    <= q_res;
        remainder   <= r_res;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_nr_seq.sv
// tb/tb_div_nr_seq.sv - self-checking bench for div_nr_seq (WIDTH=8), scoreboard plus vector table
module tb_div_nr_seq;

  localparam int W = 8;

`ifdef DIV_NR_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic         sop;
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q_s;
    logic [W-1:0] r_s;
    logic [W-1:0] q_u;
    logic [W-1:0] r_u;
    logic         dz;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int   total = 0;
  int   bad = 0;
  int   n_done = 0;
  exp_t sb_q[$];
  vec_t vecs[12];

  div_nr_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic sop, input logic [W-1:0] dd, input logic [W-1:0] dv);
    exp_t e;
    int   sdd, sdv;
    logic use_signed;
    use_signed = sop && SIGNED_EN;
    if (dv == '0) begin
      e.q = '1; e.r = dd; e.dz = 1'b1;
    end else if (use_signed) begin
      sdd = int'($signed(dd)); sdv = int'($signed(dv));
      e.q = W'(sdd / sdv); e.r = W'(sdd % sdv); e.dz = 1'b0;
    end else begin
      e.q = dd / dv; e.r = dd % dv; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: every done pops the oldest expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("done_with_empty_scoreboard", done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
      end
    end
  end

  // Called at a negedge: drives one start, then follows the op to its done pulse.
  task automatic run_op(input logic sop, input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input exp_t e, input logic hold_chk, input logic [W-1:0] hq,
                        input logic [W-1:0] hr);
    int   lat, bcnt;
    logic seen, hold_ok;
    signed_op = sop; dividend = dd; divisor = dv; start = 1'b1;
    sb_q.push_back(e);
    lat = 0; bcnt = 0; seen = 1'b0; hold_ok = 1'b1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      if (busy) bcnt++;
      if (done) seen = 1'b1;
      else if (hold_chk && (quotient !== hq || remainder !== hr)) hold_ok = 1'b0;
    end
    check("latency", lat, e.dz ? 1 : W + 2);
    check("busy_cycles", bcnt, e.dz ? 0 : W + 1);
    if (hold_chk) check("result_hold", hold_ok, 1'b1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat, d0;
    logic seen;
    vec_t v;
    exp_t e;
    logic sop;
    logic [W-1:0] rdd, rdv;

    //              sop  dd     dv     q_s    r_s    q_u    r_u    dz
    vecs[0]  = '{1'b0, 8'hC8, 8'h07, 8'h1C, 8'h04, 8'h1C, 8'h04, 1'b0};
    vecs[1]  = '{1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 8'h7C, 8'h01, 1'b0};
    vecs[2]  = '{1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 8'h00, 8'h07, 1'b0};
    vecs[3]  = '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h80, 1'b0};
    vecs[4]  = '{1'b0, 8'h37, 8'h00, 8'hFF, 8'h37, 8'hFF, 8'h37, 1'b1};
    vecs[5]  = '{1'b1, 8'h37, 8'h00, 8'hFF, 8'h37, 8'hFF, 8'h37, 1'b1};
    vecs[6]  = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 8'h16, 8'h02, 1'b0};
    vecs[8]  = '{1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 8'h05, 8'h09, 8'h00, 8'h05, 8'h00, 8'h05, 1'b0};
    vecs[10] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 8'hC8, 8'h07, 8'hF8, 8'h00, 8'h1C, 8'h04, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_dz", div_by_zero, 1'b0);

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      e.q  = (v.sop && SIGNED_EN) ? v.q_s : v.q_u;
      e.r  = (v.sop && SIGNED_EN) ? v.r_s : v.r_u;
      e.dz = v.dz;
      @(negedge clk);
      run_op(v.sop, v.dd, v.dv, e, 1'b0, '0, '0);
    end

    // start held high for a whole operation yields a single done
    @(negedge clk);
    signed_op = 1'b0; dividend = 8'd100; divisor = 8'd3; start = 1'b1;
    sb_q.push_back(exp_t'{8'd33, 8'd1, 1'b0});
    d0 = n_done; lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("held_start_latency", lat, W + 2);
    repeat (15) @(negedge clk);
    check("held_start_done_count", n_done - d0, 1);

    // back-to-back: second start in the done cycle, first result held meanwhile
    @(negedge clk);
    run_op(1'b0, 8'd200, 8'd7, exp_t'{8'd28, 8'd4, 1'b0}, 1'b0, '0, '0);
    run_op(1'b0, 8'd100, 8'd9, exp_t'{8'd11, 8'd1, 1'b0}, 1'b1, 8'd28, 8'd4);

    // reset in the middle of the iterations aborts without a done
    @(negedge clk);
    signed_op = 1'b0; dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_dz", div_by_zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    d0 = n_done;
    repeat (15) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    @(negedge clk);
    run_op(1'b0, 8'd77, 8'd5, exp_t'{8'd15, 8'd2, 1'b0}, 1'b0, '0, '0);

    // random sweep, both modes, occasional zero divisor
    for (int n = 0; n < 300; n++) begin
      sop = 1'($urandom_range(0, 1));
      rdd = W'($urandom);
      rdv = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      e = model(sop, rdd, rdv);
      @(negedge clk);
      run_op(sop, rdd, rdv, e, 1'b0, '0, '0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
